// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e       receive FSM states
//   PAR_*            parity_signal encodings ([1] = enable, [0] = even)
//   FRAME_MIN/MAX    legal range of data bits per frame
//   frames_per_word  number of frames needed to carry one word
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StDone
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_EVEN = 2'b11;

  localparam int unsigned FRAME_MIN = 5;
  localparam int unsigned FRAME_MAX = 8;

  function automatic int unsigned frames_per_word(input int unsigned data_width,
                                                  input int unsigned frame_len);
    return (data_width + frame_len - 1) / frame_len;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Signal bundle between the UART receiver and its user.
//   Rx, RX_detect, frame_length, parity_signal, stop_bits : line and configuration
//   read_data, RX_done, RX_ERROR, parity_error, frame_error, rx_busy : results and status
// master: the side driving the line/configuration; slave: the receiver.
interface uart_receiver_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Rx;
  logic                  RX_detect;
  logic [3:0]            frame_length;
  logic [1:0]            parity_signal;
  logic                  stop_bits;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  RX_done;
  logic                  RX_ERROR;
  logic                  parity_error;
  logic                  frame_error;
  logic                  rx_busy;

  modport master (
    output Rx, RX_detect, frame_length, parity_signal, stop_bits,
    input  read_data, RX_done, RX_ERROR, parity_error, frame_error, rx_busy
  );

  modport slave (
    input  Rx, RX_detect, frame_length, parity_signal, stop_bits,
    output read_data, RX_done, RX_ERROR, parity_error, frame_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
//   rx_tick  clock (16x bit-rate tick)
//   PRESETn  asynchronous active-low reset; line state resets to idle-high
//   Rx       raw serial line
//   rx_s     synchronized line
//   rx_fall  high for one tick when rx_s goes 1 -> 0
module uart_rx_sync (
  input  logic rx_tick,
  input  logic PRESETn,
  input  logic Rx,
  output logic rx_s,
  output logic rx_fall
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge rx_tick or negedge PRESETn) begin
    if (!PRESETn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= Rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  // Requires the line to be seen high before a new start is recognised.
  assign rx_fall = prev_q & ~sync_q;
endmodule

// File: rtl/uart_receiver.sv
// UART receive half: reassembles one DATA_WIDTH-bit word, LSB first, from consecutive frames
// (start, frame_length data bits, optional parity, 1 or 2 stop bits) sampled on a tick running
// at OVERSAMPLE x bit rate.
//   rx_tick  sole clock
//   PRESETn  asynchronous active-low reset
//   rx_bus   slave side of uart_receiver_if (line, configuration, word and status outputs)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             rx_tick,
  input  logic             PRESETn,
  uart_receiver_if.slave   rx_bus
);
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + FRAME_MAX);
  localparam int unsigned BitW = $clog2(DATA_WIDTH);

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .rx_tick (rx_tick),
    .PRESETn (PRESETn),
    .Rx      (rx_bus.Rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  rx_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [3:0]            frame_bits_q, frame_bits_d;
  logic                  par_acc_q, par_acc_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [3:0]            cfg_len_q, cfg_len_d;
  logic [1:0]            cfg_par_q, cfg_par_d;
  logic                  cfg_stop2_q, cfg_stop2_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  parity_error_q, parity_error_d;
  logic                  frame_error_q, frame_error_d;

  logic start_mid, bit_tick, in_word, word_full, cfg_legal, exp_par;

  assign start_mid = (cnt_q == CntW'(OVERSAMPLE / 2 - 1));
  assign bit_tick  = (cnt_q == CntW'(OVERSAMPLE - 1));
  // A non-zero bit index means a word is partially received and its config is frozen.
  assign in_word   = (bit_idx_q != '0);
  assign word_full = (bit_idx_q >= IdxW'(DATA_WIDTH));
  assign cfg_legal = (rx_bus.frame_length >= 4'(FRAME_MIN)) &&
                     (rx_bus.frame_length <= 4'(FRAME_MAX));
  assign exp_par   = (cfg_par_q == PAR_EVEN) ? par_acc_q : ~par_acc_q;

  // State register
  always_ff @(posedge rx_tick or negedge PRESETn) begin
    if (!PRESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      state_d = StWaitStart;
      StWaitStart: if (rx_fall) state_d = (in_word || cfg_legal) ? StStart : StIdle;
      StStart:     if (start_mid) state_d = rx_s ? StWaitStart : StData;
      StData: begin
        if (bit_tick && (frame_bits_q == cfg_len_q - 4'd1)) begin
          state_d = cfg_par_q[1] ? StParity : StStop1;
        end
      end
      StParity:    if (bit_tick) state_d = StStop1;
      StStop1: begin
        if (bit_tick) begin
          if (cfg_stop2_q) state_d = StStop2;
          else             state_d = word_full ? StDone : StWaitStart;
        end
      end
      StStop2:     if (bit_tick) state_d = word_full ? StDone : StWaitStart;
      StDone:      state_d = StWaitStart;
      default:     state_d = StIdle;
    endcase
    if (!rx_bus.RX_detect) state_d = StIdle;
  end

  // Datapath next-state
  always_comb begin
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    frame_bits_d   = frame_bits_q;
    par_acc_d      = par_acc_q;
    word_d         = word_q;
    cfg_len_d      = cfg_len_q;
    cfg_par_d      = cfg_par_q;
    cfg_stop2_d    = cfg_stop2_q;
    perr_d         = perr_q;
    ferr_d         = ferr_q;
    cfg_err_d      = 1'b0;
    read_data_d    = read_data_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        word_d    = '0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
      end
      StWaitStart: begin
        cnt_d = '0;
        if (rx_fall) begin
          frame_bits_d = '0;
          par_acc_d    = 1'b0;
          if (!in_word) begin
            if (cfg_legal) begin
              cfg_len_d   = rx_bus.frame_length;
              cfg_par_d   = rx_bus.parity_signal;
              cfg_stop2_d = rx_bus.stop_bits;
              perr_d      = 1'b0;
              ferr_d      = 1'b0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
      end
      StStart: cnt_d = start_mid ? '0 : cnt_q + CntW'(1);
      StData: begin
        cnt_d = bit_tick ? '0 : cnt_q + CntW'(1);
        if (bit_tick) begin
          // Bits past the word width are the zero pad of the last frame.
          if (bit_idx_q < IdxW'(DATA_WIDTH)) word_d[bit_idx_q[BitW-1:0]] = rx_s;
          bit_idx_d    = bit_idx_q + IdxW'(1);
          frame_bits_d = frame_bits_q + 4'd1;
          par_acc_d    = par_acc_q ^ rx_s;
        end
      end
      StParity: begin
        cnt_d = bit_tick ? '0 : cnt_q + CntW'(1);
        if (bit_tick && (rx_s != exp_par)) perr_d = 1'b1;
      end
      StStop1, StStop2: begin
        cnt_d = bit_tick ? '0 : cnt_q + CntW'(1);
        if (bit_tick && !rx_s) ferr_d = 1'b1;
      end
      StDone: begin
        word_d    = '0;
        bit_idx_d = '0;
      end
      default: cnt_d = '0;
    endcase

    if (!rx_bus.RX_detect) begin
      word_d    = '0;
      bit_idx_d = '0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
    end

    // Publish the word and flags so they are valid during the DONE tick.
    if (state_d == StDone) begin
      read_data_d    = word_q;
      parity_error_d = perr_d;
      frame_error_d  = ferr_d;
    end
  end

  always_ff @(posedge rx_tick or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      frame_bits_q   <= '0;
      par_acc_q      <= 1'b0;
      word_q         <= '0;
      cfg_len_q      <= 4'd8;
      cfg_par_q      <= PAR_NONE;
      cfg_stop2_q    <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      read_data_q    <= '0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      frame_bits_q   <= frame_bits_d;
      par_acc_q      <= par_acc_d;
      word_q         <= word_d;
      cfg_len_q      <= cfg_len_d;
      cfg_par_q      <= cfg_par_d;
      cfg_stop2_q    <= cfg_stop2_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      cfg_err_q      <= cfg_err_d;
      read_data_q    <= read_data_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  // Outputs
  always_comb begin
    rx_bus.read_data    = read_data_q;
    rx_bus.parity_error = parity_error_q;
    rx_bus.frame_error  = frame_error_q;
    rx_bus.RX_done      = (state_q == StDone);
    rx_bus.RX_ERROR     = ((state_q == StDone) && (parity_error_q || frame_error_q)) ||
                          cfg_err_q;
    rx_bus.rx_busy      = (state_q inside {StStart, StData, StParity, StStop1, StStop2}) ||
                          ((state_q == StWaitStart) && in_word);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver: frames are built from a word with plain
// arithmetic and the results compared to the expected word and error flags.
module tb_uart_receiver;
  localparam int OS = 16;
  localparam int DW = 32;

  logic rx_tick = 1'b0;
  logic PRESETn;

  uart_receiver_if #(.DATA_WIDTH(DW)) bus ();

  uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .rx_tick (rx_tick),
    .PRESETn (PRESETn),
    .rx_bus  (bus)
  );

  always #5 rx_tick = ~rx_tick;

  typedef struct {
    int          tick;
    logic [31:0] data;
    logic        err;
    logic        perr;
    logic        ferr;
  } done_ev_t;

  done_ev_t    ev_q[$];
  int          tick_n     = 0;
  int          done_hi    = 0;
  int          cfg_err_n  = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;
  logic [31:0] exp_rd     = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: records every RX_done pulse and every standalone RX_ERROR pulse.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge rx_tick);
      tick_n++;
      if (bus.RX_done === 1'b1) begin
        done_hi++;
        if (!done_prev) ev_q.push_back('{tick_n, bus.read_data, bus.RX_ERROR,
                                          bus.parity_error, bus.frame_error});
      end
      if (bus.RX_ERROR === 1'b1 && bus.RX_done !== 1'b1) cfg_err_n++;
      done_prev = (bus.RX_done === 1'b1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    bus.Rx = b;
    repeat (OS) @(negedge rx_tick);
  endtask

  // abort_kind: 0 none, 1 RX_detect drop, 2 PRESETn pulse (at bit 2 of frame abort_f)
  task automatic send_word(input logic [31:0] w, input int len, input logic [1:0] par,
                           input logic stop2, input int bad_par_f, input int bad_stop_f,
                           input int abort_f, input int abort_kind);
    int   nf, ones, idx, t0, hi0;
    logic b, pb, sb, exp_perr, exp_ferr;
    nf = (DW + len - 1) / len;
    bus.frame_length  = len[3:0];
    bus.parity_signal = par;
    bus.stop_bits     = stop2;
    exp_perr = par[1] && (bad_par_f >= 0) && (bad_par_f < nf);
    exp_ferr = (bad_stop_f >= 0) && (bad_stop_f < nf);
    ev_q.delete();
    hi0 = done_hi;
    t0  = 0;
    for (int f = 0; f < nf; f++) begin
      send_bit(1'b0);
      ones = 0;
      for (int j = 0; j < len; j++) begin
        idx = f * len + j;
        b   = (idx < DW) ? w[idx] : 1'b0;
        ones += int'(b);
        if (f == abort_f && j == 2 && abort_kind != 0) begin
          if (abort_kind == 1) begin
            bus.RX_detect = 1'b0;
            repeat (2) @(negedge rx_tick);
            bus.Rx = 1'b1;
            repeat (4) @(negedge rx_tick);
            bus.RX_detect = 1'b1;
          end else begin
            PRESETn = 1'b0;
            bus.Rx  = 1'b1;
            repeat (2) @(negedge rx_tick);
            PRESETn = 1'b1;
            exp_rd  = '0;
          end
          repeat (3 * OS) @(negedge rx_tick);
          check_eq("abort_no_done", ev_q.size(), 0);
          check_eq("abort_read_data", bus.read_data, exp_rd);
          check_eq("abort_busy", bus.rx_busy, 0);
          return;
        end
        if (f == 0 && j == 2) check_eq("busy_mid_word", bus.rx_busy, 1);
        send_bit(b);
      end
      if (par[1]) begin
        pb = (par == 2'b11) ? ones[0] : ~ones[0];
        if (f == bad_par_f) pb = ~pb;
        send_bit(pb);
      end
      sb = (f == bad_stop_f) ? 1'b0 : 1'b1;
      if (stop2) send_bit(sb);
      t0 = tick_n;
      send_bit(sb);
      send_bit(1'b1);
    end
    for (int k = 0; k < 2 * OS && ev_q.size() == 0; k++) @(negedge rx_tick);
    check_eq("done_seen", ev_q.size(), 1);
    check_eq("done_ticks", done_hi - hi0, 1);
    check_eq("busy_after", bus.rx_busy, 0);
    if (ev_q.size() > 0) begin
      check_eq("read_data", ev_q[0].data, w);
      check_eq("parity_error", ev_q[0].perr, exp_perr);
      check_eq("frame_error", ev_q[0].ferr, exp_ferr);
      check_eq("RX_ERROR", ev_q[0].err, exp_perr | exp_ferr);
      check_eq("done_latency", ((ev_q[0].tick - t0) > 0) && ((ev_q[0].tick - t0) <= OS), 1);
    end
    exp_rd = w;
  endtask

  initial begin
    int          cfg0, len, nf, bp, bs;
    logic [1:0]  par;
    logic [31:0] w;
    int          bad_len[2];
    bad_len = '{4, 9};

    PRESETn           = 1'b0;
    bus.Rx            = 1'b1;
    bus.RX_detect     = 1'b1;
    bus.frame_length  = 4'd8;
    bus.parity_signal = 2'b00;
    bus.stop_bits     = 1'b0;
    repeat (3) @(negedge rx_tick);
    check_eq("rst_read_data", bus.read_data, 0);
    check_eq("rst_RX_done", bus.RX_done, 0);
    check_eq("rst_RX_ERROR", bus.RX_ERROR, 0);
    check_eq("rst_parity_error", bus.parity_error, 0);
    check_eq("rst_frame_error", bus.frame_error, 0);
    check_eq("rst_rx_busy", bus.rx_busy, 0);
    PRESETn = 1'b1;
    repeat (OS) @(negedge rx_tick);

    send_word(32'hA5C3_0F96, 8, 2'b00, 1'b0, -1, -1, -1, 0);
    send_word(32'hDEAD_BEEF, 5, 2'b10, 1'b1, -1, -1, -1, 0);
    send_word(32'h0BAD_F00D, 8, 2'b11, 1'b0, 2, -1, -1, 0);
    send_word(32'h3C3C_A5A5, 6, 2'b00, 1'b0, -1, 3, -1, 0);
    send_word(32'h5555_AAAA, 6, 2'b00, 1'b0, -1, -1, -1, 0);

    // Short low pulse while waiting: start is seen but rejected at mid-bit.
    cfg0 = cfg_err_n;
    ev_q.delete();
    bus.Rx = 1'b0;
    repeat (4) @(negedge rx_tick);
    bus.Rx = 1'b1;
    repeat (2) @(negedge rx_tick);
    check_eq("glitch_busy_high", bus.rx_busy, 1);
    repeat (2 * OS) @(negedge rx_tick);
    check_eq("glitch_busy_low", bus.rx_busy, 0);
    check_eq("glitch_no_done", ev_q.size(), 0);
    check_eq("glitch_no_error", cfg_err_n - cfg0, 0);
    send_word(32'hC0FF_EE11, 7, 2'b11, 1'b1, -1, -1, -1, 0);

    // Illegal frame lengths just outside the legal range.
    foreach (bad_len[i]) begin
      cfg0 = cfg_err_n;
      ev_q.delete();
      bus.frame_length = bad_len[i][3:0];
      send_bit(1'b0);
      send_bit(1'b1);
      repeat (OS) @(negedge rx_tick);
      check_eq("badcfg_error_pulse", cfg_err_n - cfg0, 1);
      check_eq("badcfg_no_done", ev_q.size(), 0);
      check_eq("badcfg_busy", bus.rx_busy, 0);
    end

    send_word(32'hFFFF_0000, 8, 2'b00, 1'b0, -1, -1, 1, 1);
    send_word(32'h1234_5678, 8, 2'b00, 1'b0, -1, -1, -1, 0);
    send_word(32'h8765_4321, 6, 2'b10, 1'b0, -1, -1, 2, 2);
    send_word(32'h1234_5678, 5, 2'b11, 1'b1, -1, -1, -1, 0);

    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(5, 8);
      nf  = (DW + len - 1) / len;
      case ($urandom_range(0, 2))
        0:       par = 2'b00;
        1:       par = 2'b10;
        default: par = 2'b11;
      endcase
      w  = $urandom;
      bp = (par[1] && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nf - 1)) : -1;
      bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nf - 1)) : -1;
      send_word(w, len, par, 1'($urandom_range(0, 1)), bp, bs, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive half of the UART.
- Reassembles one `DATA_WIDTH`-bit word from a train of frames on `Rx`. Each frame is: start bit, `frame_length` data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
- Word bits are carried LSB-first across consecutive frames; the last frame is zero-padded.
- Samples the line with a 16x oversampled tick. Checks parity and stop bits per frame, and presents the word with a one-tick done pulse and error status.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (from Defines.sv, 32): received word width.
- OVERSAMPLE, 16: rx_tick periods per bit; must be even and >=8.

Ports:
- rx_tick  input  1  sole clock; 16x bit-rate tick; all state updates on posedge.
- PRESETn  input  1  asynchronous active-low reset.
- Rx  input  1  serial line, asynchronous, idles high.
- RX_detect  input  1  receive enable; low forces IDLE synchronously.
- frame_length  input  4  data bits per frame; legal values 5..8.
- parity_signal  input  2  [1]=parity enable; 2'b10 odd (parity bit = ~^bits); 2'b11 even (parity bit = ^bits).
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- read_data  output  DATA_WIDTH  last completed word; holds until next completion.
- RX_done  output  1  one-tick pulse; read_data valid.
- RX_ERROR  output  1  one-tick pulse with RX_done if any frame erred; also pulses on illegal config.
- parity_error  output  1  word-level sticky flag, updated at RX_done.
- frame_error  output  1  word-level sticky flag, updated at RX_done.
- rx_busy  output  1  high from start-bit acceptance to RX_done or abort.

Behaviour:
- Reset values: read_data=0, RX_done=0, RX_ERROR=0, parity_error=0, frame_error=0, rx_busy=0, FSM=IDLE, all counters 0.
- Input conditioning: Rx passes a 2-flop synchronizer, reset value 1. Start detection is a falling edge of the synchronized line (previous 1, current 0).
- Sampling: a sample counter runs 0..OVERSAMPLE-1.
  - Start bit is sampled at count OVERSAMPLE/2-1 after the edge.
  - Every later bit is sampled each OVERSAMPLE ticks after that.
- Configuration: frame_length, parity_signal and stop_bits are latched at the first start bit of a word. They are frozen until RX_done or abort.
- Illegal config: frame_length outside 5..8 at a start edge gives a RX_ERROR pulse and the FSM stays in IDLE.
- FSM states and transitions:
  - IDLE: waits for RX_detect=1, then goes to WAIT_START.
  - WAIT_START: on a falling edge, go to START.
  - START: at mid-bit, if the line is 0 go to DATA; if 1 it is a glitch, return to WAIT_START with no error. A word already in progress continues.
  - DATA: samples frame_length bits. Each bit is written to word[bit_idx] if bit_idx<DATA_WIDTH, otherwise discarded (pad). bit_idx increments every bit. After the last bit, go to PARITY if enabled, else STOP1.
  - PARITY: the sample is compared to the parity computed over that frame's frame_length sampled bits, pad included. A mismatch sets parity_error.
  - STOP1: a 0 sample sets frame_error. Go to STOP2 if stop_bits=1. Otherwise go to DONE if bit_idx>=DATA_WIDTH, else WAIT_START.
  - STOP2: same check as STOP1, then the same bit_idx decision.
  - DONE: one tick. Drives RX_done=1 and read_data=word. RX_ERROR = parity_error|frame_error. Clears the word and bit_idx, then goes to WAIT_START (or IDLE if RX_detect=0).
- Frames per word = ceil(DATA_WIDTH/frame_length). For DATA_WIDTH=32: L=8→4, L=7→5, L=6→6, L=5→7.
- After a frame error, the FSM does not look for the next start until the line is seen high; the edge detector enforces this.
- Latency: RX_done is asserted the tick after the mid-sample of the final stop bit.
- Aborts:
  - RX_detect falling mid-word: next tick goes to IDLE, the partial word is discarded, no RX_done, and flags are cleared for the next word.
  - PRESETn assertion: immediate reset to reset values.
- The sticky error flags reset at the start of each word.

Decomposition:
- Shared package uart_pkg holds:
  - the rx state enum;
  - parity encoding constants PAR_NONE, PAR_ODD=2'b10, PAR_EVEN=2'b11;
  - FRAME_MIN=5, FRAME_MAX=8;
  - the frames-per-word function.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect, with outputs rx_s and rx_fall.

Test Plan:
- L=8, no parity, 1 stop, word 32'hA5C3_0F96 (bytes 96,0F,C3,A5) -> read_data=32'hA5C30F96, RX_done one tick, RX_ERROR=0.
- L=5, odd parity (2'b10), 2 stops, word 32'hDEAD_BEEF over 7 frames with 3 pad zeros -> read_data=32'hDEADBEEF, no errors.
- L=8, even parity, parity bit of frame 2 inverted -> read_data still correct, parity_error=1, RX_ERROR=1 coincident with RX_done.
- L=6, stop bit of frame 3 driven 0 -> frame_error=1 and RX_ERROR=1 at RX_done; the next clean word has both flags 0.
- Rx low pulse of 4 ticks while idle -> no start; rx_busy returns to 0; the following valid word decodes correctly.
- RX_detect dropped in frame 2 (and separately PRESETn pulsed mid-frame) -> no RX_done, read_data unchanged; the next word 32'h1234_5678 decodes correctly.
